// File: rtl/calc2_pkg.sv
// Shared calc2 protocol types and widths for the requester port.
package calc2_pkg;

  localparam int unsigned CMD_W    = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TAG_W    = 2;
  localparam int unsigned NUM_TAGS = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2,
    RESP_IERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    TAG_FREE = 2'd0,
    TAG_PEND = 2'd1,
    TAG_DONE = 2'd2
  } tag_state_e;

  typedef struct packed {
    resp_e             resp;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } rsp_entry_t;

endpackage

// File: rtl/calc2_rsp_fifo.sv
// Four-entry result FIFO holding captured {resp, data, tag} in arrival order.
module calc2_rsp_fifo
  import calc2_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  rsp_entry_t entry_i,
  input  logic       pop_i,
  output rsp_entry_t head_o,
  output logic       empty_o,
  output logic       full_o
);

  rsp_entry_t       mem_q [NUM_TAGS];
  logic [TAG_W-1:0] wr_q;
  logic [TAG_W-1:0] rd_q;
  logic [2:0]       cnt_q;

  // Storage needs no reset: an entry is only observed after it was written.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= entry_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + TAG_W'(1);
      if (pop_i)  rd_q <= rd_q + TAG_W'(1);
      cnt_q <= cnt_q + 3'(push_i) - 3'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == 3'd0);
  assign full_o  = (cnt_q == 3'(NUM_TAGS));

endmodule

// File: rtl/calc2_req_port.sv
// calc2 requester: tag allocation, two-cycle request serialisation,
// tagged response capture into a result FIFO, and a pending-tag watchdog.
module calc2_req_port
  import calc2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [CMD_W-1:0]  op_cmd,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [TAG_W-1:0]  op_tag,
  output logic [CMD_W-1:0]  req_cmd_out,
  output logic [DATA_W-1:0] req_data_out,
  output logic [TAG_W-1:0]  req_tag_out,
  input  logic [1:0]        out_resp,
  input  logic [DATA_W-1:0] out_data,
  input  logic [TAG_W-1:0]  out_tag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [1:0]        res_resp,
  output logic [DATA_W-1:0] res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic [2:0]        outstanding,
  output logic              err_spurious,
  output logic              err_timeout
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {S_IDLE, S_SEND_B} fsm_e;

  fsm_e              state_q;
  logic [CMD_W-1:0]  req_cmd_q;
  logic [DATA_W-1:0] req_data_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic [DATA_W-1:0] op_b_q;
  tag_state_e        tag_st_q [NUM_TAGS];
  tag_state_e        tag_st_d [NUM_TAGS];
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              spur_q, tmo_q;

  logic       free_found, pend_any, accept, rsp_seen, cap_hit, pop, wd_fire;
  logic       fifo_empty, fifo_full;
  logic [2:0] busy_cnt;
  rsp_entry_t cap_entry, head;

  always_comb begin
    free_found = 1'b0;
    pend_any   = 1'b0;
    op_tag     = '0;
    busy_cnt   = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (!free_found && tag_st_q[i] == TAG_FREE) begin
        free_found = 1'b1;
        op_tag     = TAG_W'(i);
      end
      if (tag_st_q[i] == TAG_PEND) pend_any = 1'b1;
      if (tag_st_q[i] != TAG_FREE) busy_cnt = busy_cnt + 3'd1;
    end
  end

  assign op_ready = (state_q == S_IDLE) && free_found;
  assign accept   = op_valid && op_ready;
  assign rsp_seen = (out_resp != RESP_NONE);
  assign cap_hit  = rsp_seen && (tag_st_q[out_tag] == TAG_PEND);
  assign pop      = res_valid && res_ready;
  // A capture on the expiry edge keeps the watchdog from firing.
  assign wd_fire  = pend_any && !cap_hit && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign cap_entry = '{resp: resp_e'(out_resp), data: out_data, tag: out_tag};

  // Accept, capture and pop always touch distinct tags (FREE/PEND/DONE).
  always_comb begin
    tag_st_d = tag_st_q;
    if (wd_fire) begin
      for (int unsigned i = 0; i < NUM_TAGS; i++)
        if (tag_st_q[i] == TAG_PEND) tag_st_d[i] = TAG_FREE;
    end
    if (cap_hit) tag_st_d[out_tag] = TAG_DONE;
    if (pop)     tag_st_d[head.tag] = TAG_FREE;
    if (accept)  tag_st_d[op_tag] = TAG_PEND;
  end

  always_comb begin
    wd_d = wd_q + WD_W'(1);
    if (cap_hit || !pend_any || wd_fire) wd_d = '0;
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      req_cmd_q  <= '0;
      req_data_q <= '0;
      req_tag_q  <= '0;
      op_b_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            req_cmd_q  <= op_cmd;
            req_data_q <= op_a;
            req_tag_q  <= op_tag;
            op_b_q     <= op_b;
            state_q    <= S_SEND_B;
          end else begin
            req_cmd_q  <= '0;
            req_data_q <= '0;
            req_tag_q  <= '0;
          end
        end
        S_SEND_B: begin
          req_cmd_q  <= '0;
          req_data_q <= op_b_q;
          req_tag_q  <= '0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      tag_st_q <= '{default: TAG_FREE};
      wd_q     <= '0;
      spur_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      tag_st_q <= tag_st_d;
      wd_q     <= wd_d;
      if (rsp_seen && !cap_hit) spur_q <= 1'b1;
      if (wd_fire)              tmo_q  <= 1'b1;
    end
  end

  calc2_rsp_fifo u_fifo (
    .clk_i   (c_clk),
    .rst_ni  (reset),
    .push_i  (cap_hit),
    .entry_i (cap_entry),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assert property (@(posedge c_clk) disable iff (!reset) !(cap_hit && fifo_full && !pop));

  assign req_cmd_out  = req_cmd_q;
  assign req_data_out = req_data_q;
  assign req_tag_out  = req_tag_q;
  assign res_valid    = !fifo_empty;
  assign res_resp     = fifo_empty ? '0 : head.resp;
  assign res_data     = fifo_empty ? '0 : head.data;
  assign res_tag      = fifo_empty ? '0 : head.tag;
  assign outstanding  = busy_cnt;
  assign err_spurious = spur_q;
  assign err_timeout  = tmo_q;

endmodule
